// File: rtl/fifo_uart_drain.sv
// Drains captured bytes from the sniffer FIFO and sends each one as an 8N1 UART frame.
// The FIFO read strobe is issued from IDLE, and the returned byte is latched one cycle later.
module fifo_uart_drain #(
  parameter int BAUD_DIV = 104,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [7:0]       fifo_data,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] byte_cnt
);

  typedef enum logic [2:0] {IDLE, LATCH, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t           state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             rd_en_q, rd_en_d;
  logic             busy_q, busy_d;
  logic             tx_q, tx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             go, term;

  assign go   = enable & ~fifo_empty;
  assign term = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    rd_en_d = 1'b0;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        // The strobe cycle itself is spent in IDLE; LATCH follows once it has been issued.
        if (rd_en_q) begin
          state_d = LATCH;
        end else if (go) begin
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      LATCH: begin
        baud_d  = '0;
        shift_d = fifo_data;
        state_d = START;
      end
      START: begin
        if (term) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (term) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      STOP: begin
        if (term) begin
          baud_d  = '0;
          state_d = IDLE;
          cnt_d   = cnt_q + 1'b1;
          busy_d  = 1'b0;
          // Evaluating the first IDLE decision here keeps back-to-back frames 10*BAUD_DIV+2 apart.
          if (go) begin
            rd_en_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign busy       = busy_q;
  assign tx         = tx_q;
  assign byte_cnt   = cnt_q;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain at BAUD_DIV=4: single byte, burst, enable gating,
// empty boundary in STOP and reset mid-frame, against a small registered-read FIFO model.
module tb_fifo_uart_drain;

  localparam int BD    = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [7:0]       fifo_data;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] byte_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;

  fifo_uart_drain #(.BAUD_DIV(BD), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .tx         (tx),
    .busy       (busy),
    .byte_cnt   (byte_cnt)
  );

  always #5 clk = ~clk;

  // Registered-read FIFO: data appears the cycle after the strobe.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr % 32];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 32] = b;
    wr_ptr++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Leaves the caller at the negedge of the strobe cycle.
  task automatic wait_rd(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (fifo_rd_en) break;
    end
    chk("rd_en_seen", 32'(fifo_rd_en), 32'd1);
    chk("rd_en_busy", 32'(busy), 32'd1);
  endtask

  // Starting at the strobe cycle k, checks cycles k+1..k+41 of one frame.
  // act 1 drops enable, act 2 pushes act_byte, both at offset act_at.
  task automatic check_frame(input logic [7:0] b, input int act, input int act_at,
                             input logic [7:0] act_byte);
    logic [9:0] bits;
    int bi;
    bits = {1'b1, b, 1'b0};
    for (int c = 1; c <= 41; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("latch_tx", 32'(tx), 32'd1);
      end else begin
        bi = (c - 2) / BD;
        chk($sformatf("tx_%02h_bit%0d", b, bi), 32'(tx), 32'(bits[bi]));
      end
      chk("frame_busy", 32'(busy), 32'd1);
      chk("frame_no_rd", 32'(fifo_rd_en), 32'd0);
      if (c == act_at && act == 1) enable = 1'b0;
      if (c == act_at && act == 2) push(act_byte);
    end
  endtask

  task automatic no_rd(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (fifo_rd_en) seen++;
    end
    chk("no_rd_pulses", 32'(seen), 32'd0);
  endtask

  initial begin
    logic [7:0] burst [8];
    burst = '{8'h18, 8'h29, 8'h3A, 8'h4B, 8'h5C, 8'h6D, 8'h7E, 8'hBF};
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("init_tx", 32'(tx), 32'd1);
    chk("init_busy", 32'(busy), 32'd0);

    // Single byte
    enable = 1'b1;
    no_rd(5);
    push(8'hA5);
    wait_rd(5);
    check_frame(8'hA5, 0, 0, 8'h00);
    @(negedge clk);
    chk("single_byte_cnt", 32'(byte_cnt), 32'd1);
    chk("single_busy_off", 32'(busy), 32'd0);
    chk("single_rd_off", 32'(fifo_rd_en), 32'd0);

    // Burst of 8, back-to-back strobes 42 clocks apart
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 8; i++) push(burst[i]);
    enable = 1'b1;
    wait_rd(5);
    for (int i = 0; i < 8; i++) begin
      check_frame(burst[i], 0, 0, 8'h00);
      @(negedge clk);
      chk($sformatf("burst_rd_%0d", i + 1), 32'(fifo_rd_en), (i < 7) ? 32'd1 : 32'd0);
    end
    no_rd(60);
    chk("burst_byte_cnt", 32'(byte_cnt), 32'd8);

    // Enable dropped during data bit 2 of byte 2
    do_reset();
    enable = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    enable = 1'b1;
    wait_rd(5);
    check_frame(8'h11, 0, 0, 8'h00);
    @(negedge clk);
    chk("en_rd_2", 32'(fifo_rd_en), 32'd1);
    check_frame(8'h22, 1, 14, 8'h00);
    no_rd(30);
    chk("en_hold_cnt", 32'(byte_cnt), 32'd2);
    chk("en_hold_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    chk("en_reraise_rd", 32'(fifo_rd_en), 32'd1);
    check_frame(8'h33, 0, 0, 8'h00);
    @(negedge clk);
    chk("en_rd_4", 32'(fifo_rd_en), 32'd1);
    check_frame(8'h44, 0, 0, 8'h00);
    @(negedge clk);
    chk("en_byte_cnt", 32'(byte_cnt), 32'd4);
    chk("en_rd_off", 32'(fifo_rd_en), 32'd0);

    // FIFO becomes non-empty during STOP
    do_reset();
    push(8'h5A);
    wait_rd(5);
    check_frame(8'h5A, 2, 38, 8'hC3);
    @(negedge clk);
    chk("empty_boundary_rd", 32'(fifo_rd_en), 32'd1);
    check_frame(8'hC3, 0, 0, 8'h00);
    @(negedge clk);
    chk("empty_byte_cnt", 32'(byte_cnt), 32'd2);

    // Reset during data bit 3
    do_reset();
    push(8'h96); push(8'h69);
    wait_rd(5);
    repeat (18) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_rd(5);
    check_frame(8'h69, 0, 0, 8'h00);
    @(negedge clk);
    chk("midrst_byte_cnt", 32'(byte_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
